soc2_ram_stream_reader: RTL and testbench

Burst read engine that sits directly in front of the SoC2 on-chip RAM slave and acts as its only master. It reads a programmed run of 32-bit words from the RAM and emits them as an Avalon-ST packet with ready/valid backpressure. It absorbs the RAM's fixed one-cycle read latency with credit-based issue into a small output FIFO.

---
 rtl/soc2_pkg.sv | 6 +
 rtl/soc2_sync_fifo.sv | 34 +++
 rtl/soc2_ram_stream_reader.sv | 117 +++++++++++
 tb/tb_soc2_ram_stream_reader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/soc2_pkg.sv
// soc2_pkg: shared FSM state type and on-chip RAM geometry for SoC2 blocks
package soc2_pkg;
    localparam int RAM_ADDR_W = 13;
    localparam int RAM_WORDS = 5120;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/soc2_sync_fifo.sv
// soc2_sync_fifo: DATA_W x DEPTH synchronous FIFO, head word read straight from storage registers
module soc2_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    assign rdata = mem[rptr];
    assign empty = count == '0;
endmodule

// File: rtl/soc2_ram_stream_reader.sv
// soc2_ram_stream_reader: burst reader from the SoC2 on-chip RAM into an Avalon-ST packet,
// issuing reads against FIFO credit so the one-cycle RAM latency never overflows the FIFO
module soc2_ram_stream_reader
    import soc2_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = 32,
    parameter int NUM_WORDS = RAM_WORDS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_startofpacket,
    output logic              st_endofpacket
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt, addr_nxt;
    logic [ADDR_W:0] rd_left, rd_left_nxt, len_q, beat;
    logic [CW-1:0] count, cnt_nxt;
    logic infl, cs_nxt, pop, empty, credit;

    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(NUM_WORDS - 1)) ? '0 : a + 1'b1;
    endfunction

    // issue for the next cycle is decided on next cycle's occupancy plus this cycle's read
    always_comb begin
        pop = !empty && st_ready;
        cnt_nxt = count + CW'(infl) - CW'(pop);
        credit = ({1'b0, cnt_nxt} + {{CW{1'b0}}, ram_chipselect}) < (CW+1)'(FIFO_DEPTH);
        state_nxt = state;
        rd_addr_nxt = rd_addr;
        rd_left_nxt = rd_left;
        addr_nxt = ram_address;
        cs_nxt = 1'b0;
        case (state)
            IDLE:
                if (start && length != '0) begin
                    state_nxt = READ;
                    cs_nxt = 1'b1;
                    addr_nxt = base_addr;
                    rd_addr_nxt = inc(base_addr);
                    rd_left_nxt = length - 1'b1;
                end else if (start) state_nxt = DONE;
            READ:
                if (rd_left == '0) state_nxt = DRAIN;
                else if (credit) begin
                    cs_nxt = 1'b1;
                    addr_nxt = rd_addr;
                    rd_addr_nxt = inc(rd_addr);
                    rd_left_nxt = rd_left - 1'b1;
                end
            DRAIN: state_nxt = (cnt_nxt == '0 && !ram_chipselect) ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            rd_addr <= '0;
            rd_left <= '0;
            ram_address <= '0;
            ram_chipselect <= 1'b0;
            infl <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            len_q <= '0;
            beat <= '0;
        end else begin
            state <= state_nxt;
            rd_addr <= rd_addr_nxt;
            rd_left <= rd_left_nxt;
            ram_address <= addr_nxt;
            ram_chipselect <= cs_nxt;
            infl <= ram_chipselect;
            busy <= state_nxt == READ || state_nxt == DRAIN;
            done <= state_nxt == DONE;
            if (state == IDLE && start) begin
                len_q <= length;
                beat <= '0;
            end else if (pop) beat <= beat + 1'b1;
        end

    soc2_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(infl),
        .pop(pop),
        .wdata(ram_readdata),
        .rdata(st_data),
        .count(count),
        .empty(empty)
    );

    assign st_valid = !empty;
    assign st_startofpacket = !empty && beat == '0;
    assign st_endofpacket = !empty && beat == len_q - 1'b1;
    assign ram_write = 1'b0;
    assign ram_byteenable = 4'hF;
    assign ram_clken = 1'b1;
endmodule

// File: tb/tb_soc2_ram_stream_reader.sv
// tb_soc2_ram_stream_reader: directed and randomized packets against a RAM model and packet scoreboard
module tb_soc2_ram_stream_reader;
    localparam int AW = 13, DW = 32, NW = 5120, FD = 4;
    logic clk = 0, rst_n = 0, start = 0, st_ready = 1;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0] length = '0;
    logic busy, done, ram_chipselect, ram_write, ram_clken, st_valid, st_sop, st_eop;
    logic [AW-1:0] ram_address;
    logic [3:0] ram_byteenable;
    logic [DW-1:0] ram_readdata = '0, st_data;
    logic [DW-1:0] ram [NW];
    int total = 0, bad = 0, cyc = 0, t0 = 0;
    int first_cs, first_busy, first_valid, last_acc, done_cyc, done_cnt, issued, popped;
    logic done_busy, prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] got_data [$];
    logic got_sop [$], got_eop [$];
    int got_addr [$];

    soc2_ram_stream_reader dut (
        .clk(clk), .reset_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_startofpacket(st_sop), .st_endofpacket(st_eop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ram_chipselect && ram_clken && ram_address < AW'(NW)) ram_readdata <= ram[ram_address];

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (ram_chipselect) begin
            chk("addr_range", longint'(ram_address < AW'(NW)), 1);
            chk("credit", longint'((issued - popped) < FD), 1);
            if (first_cs < 0) first_cs = cyc;
            got_addr.push_back(int'(ram_address));
            issued++;
        end
        if (prev_stall) begin
            chk("stall_valid", longint'(st_valid), 1);
            chk("stall_data", longint'(st_data), longint'(prev_data));
        end
        if (busy && first_busy < 0) first_busy = cyc;
        if (st_valid && first_valid < 0) first_valid = cyc;
        if (st_valid && st_ready) begin
            got_data.push_back(st_data);
            got_sop.push_back(st_sop);
            got_eop.push_back(st_eop);
            last_acc = cyc;
            popped++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_busy = busy;
        end
        prev_stall = st_valid && !st_ready;
        prev_data = st_data;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        first_cs = -1; first_busy = -1; first_valid = -1; last_acc = -1; done_cyc = -1;
        done_cnt = 0; issued = 0; popped = 0; done_busy = 0; prev_stall = 0;
        got_data.delete(); got_sop.delete(); got_eop.delete(); got_addr.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_cs"}, longint'(ram_chipselect), 0);
        chk({tag, "_addr"}, longint'(ram_address), 0);
        chk({tag, "_valid"}, longint'(st_valid), 0);
        chk({tag, "_sop"}, longint'(st_sop), 0);
        chk({tag, "_eop"}, longint'(st_eop), 0);
        chk({tag, "_data"}, longint'(st_data), 0);
    endtask

    task automatic run(input int base, input int len, input bit rnd, input bit inj, input string tag);
        int a, n;
        clear_mon();
        base_addr = AW'(base);
        length = (AW+1)'(len);
        start = 1;
        t0 = cyc;
        cycle();
        start = 0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            if (inj && i == 3) begin
                start = 1;
                base_addr = AW'((base + 77) % NW);
                length = 5;
            end else start = 0;
            if (rnd) st_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        start = 0;
        st_ready = 1;
        chk({tag, "_done_seen"}, longint'(done_cnt > 0), 1);
        repeat (5) cycle();
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_busy_at_done"}, longint'(done_busy), 0);
        chk({tag, "_beats"}, got_data.size(), len);
        chk({tag, "_issues"}, got_addr.size(), len);
        chk({tag, "_done_after_last"}, done_cyc, len == 0 ? t0 + 1 : last_acc + 1);
        n = got_data.size() < len ? got_data.size() : len;
        for (int k = 0; k < n; k++) begin
            a = (base + k) % NW;
            chk($sformatf("%s_data%0d", tag, k), longint'(got_data[k]), longint'(ram[a]));
            chk($sformatf("%s_sop%0d", tag, k), longint'(got_sop[k]), longint'(k == 0));
            chk($sformatf("%s_eop%0d", tag, k), longint'(got_eop[k]), longint'(k == len - 1));
        end
        n = got_addr.size() < len ? got_addr.size() : len;
        for (int k = 0; k < n; k++) chk($sformatf("%s_addr%0d", tag, k), got_addr[k], (base + k) % NW);
    endtask

    initial begin
        clear_mon();
        for (int i = 0; i < NW; i++) ram[i] = DW'(i);
        repeat (3) cycle();
        chk_zero("reset");
        chk("tie_write", longint'(ram_write), 0);
        chk("tie_be", longint'(ram_byteenable), 15);
        chk("tie_clken", longint'(ram_clken), 1);
        rst_n = 1;
        repeat (2) cycle();

        run(16, 8, 0, 0, "basic");
        chk("basic_first_cs", first_cs, t0 + 1);
        chk("basic_first_busy", first_busy, t0 + 1);
        chk("basic_first_valid", first_valid, t0 + 3);
        chk("basic_back_to_back", last_acc - first_valid, 7);

        run(5118, 4, 0, 0, "wrap");

        for (int i = 0; i < NW; i++) ram[i] = $urandom;
        run(int'($urandom_range(0, NW - 1)), 64, 1, 0, "bp");
        run(int'($urandom_range(NW - 40, NW - 1)), 64, 1, 0, "bp_wrap");

        run(100, 0, 0, 0, "len0");
        chk("len0_no_cs", longint'(first_cs < 0), 1);
        chk("len0_no_valid", longint'(first_valid < 0), 1);
        chk("len0_no_busy", longint'(first_busy < 0), 1);

        run(int'($urandom_range(0, NW - 1)), 1, 0, 0, "len1");
        run(300, 16, 1, 1, "illegal_start");

        clear_mon();
        base_addr = AW'($urandom_range(0, NW - 1));
        length = 32;
        start = 1;
        cycle();
        start = 0;
        repeat (12) begin
            st_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("pre_rst_busy", longint'(busy), 1);
        rst_n = 0;
        #1;
        chk_zero("rst_mid");
        repeat (3) cycle();
        rst_n = 1;
        st_ready = 1;
        repeat (4) cycle();
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle_valid", longint'(st_valid), 0);
        run(int'($urandom_range(0, NW - 1)), 6, 1, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
